gate_bank: RTL and testbench

Parametrised, registered multi-channel two-input logic gate for the CPLD demo board. Each of WIDTH channels combines one bit of `a` with the same bit of `b` under a runtime-selected operation (OR, AND, XOR, NOR). Inputs come from board switches and buttons, so every input bit is synchronised and debounced before use. Outputs are registered, and a one-cycle change strobe is provided for downstream LEDs and counters.

---
 rtl/gate_bank_pkg.sv | 18 +
 rtl/debounce_bit.sv | 53 +++++
 rtl/gate_bank.sv | 62 ++++++
 tb/tb_gate_bank.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/gate_bank_pkg.sv
// Shared constants and the per-bit gate operation for gate_bank.
package gate_bank_pkg;

    localparam logic [1:0] MODE_OR  = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_XOR = 2'd2;
    localparam logic [1:0] MODE_NOR = 2'd3;

    function automatic logic gate_op(input logic x, input logic y, input logic [1:0] mode);
        case (mode)
            MODE_OR:  return x | y;
            MODE_AND: return x & y;
            MODE_XOR: return x ^ y;
            default:  return ~(x | y);
        endcase
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One input bit: 2-FF synchroniser followed by a stable-count debounce filter.
module debounce_bit #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    generate
        if (DB_CYCLES == 0) begin : g_bypass
            assign q = s2;
        end else begin : g_filter
            localparam int unsigned CW = $clog2(DB_CYCLES + 1);
            localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

            logic [CW-1:0] cnt;
            logic          f;

            // Any return to the filtered level before acceptance restarts the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt <= '0;
                    f   <= 1'b0;
                end else if (s2 == f) begin
                    cnt <= '0;
                end else if (cnt != LAST) begin
                    cnt <= cnt + CW'(1);
                end else begin
                    f   <= s2;
                    cnt <= '0;
                end
            end

            assign q = f;
        end
    endgenerate

endmodule

// File: rtl/gate_bank.sv
// Registered multi-channel two-input gate with debounced inputs and a change strobe.
module gate_bank
    import gate_bank_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] c,
    output logic             c_any,
    output logic             changed
);

    logic [WIDTH-1:0] fa;
    logic [WIDTH-1:0] fb;
    logic [WIDTH-1:0] c_next;
    logic [1:0]       mode_q;

    generate
        for (genvar i = 0; i < int'(WIDTH); i++) begin : g_ch
            debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db_a (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (a[i]),
                .q     (fa[i])
            );
            debounce_bit #(.DB_CYCLES(DB_CYCLES)) u_db_b (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (b[i]),
                .q     (fb[i])
            );
        end
    endgenerate

    always_comb begin
        c_next = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            c_next[i] = gate_op(fa[i], fb[i], mode_q);
        end
    end

    // Only the registered mode feeds the gates, so mode edges cannot glitch c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_OR;
            c       <= '0;
            changed <= 1'b0;
        end else begin
            mode_q  <= mode;
            c       <= c_next;
            changed <= (c_next != c);
        end
    end

    assign c_any = |c;

endmodule

// File: tb/tb_gate_bank.sv
// Self-checking bench for gate_bank: debounced 4-channel instance and 16-channel bypass instance.
module tb_gate_bank;
    import gate_bank_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  a, b;
    logic [1:0]  mode;
    logic [3:0]  c;
    logic        c_any, changed;

    logic        rst_n_bp;
    logic [15:0] a_bp, b_bp;
    logic [1:0]  mode_bp;
    logic [15:0] c_bp;
    logic        c_any_bp, changed_bp;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gate_bank #(.WIDTH(4), .DB_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .mode(mode),
        .c(c), .c_any(c_any), .changed(changed)
    );

    gate_bank #(.WIDTH(16), .DB_CYCLES(0)) dut_bp (
        .clk(clk), .rst_n(rst_n_bp), .a(a_bp), .b(b_bp), .mode(mode_bp),
        .c(c_bp), .c_any(c_any_bp), .changed(changed_bp)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] mode;
        int         lat;
        logic [3:0] exp_c;
    } vec_t;

    vec_t        vecs[12];
    logic [15:0] sb[$];
    logic [15:0] cur;
    logic [15:0] e;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Hold for n-1 edges expecting no change, then pop the expected value at edge n.
    task automatic expect_after(input string name, input int n);
        for (int k = 1; k < n; k++) begin
            step();
            check({name, " hold c"}, 16'(c), cur);
            check({name, " hold changed"}, 16'(changed), 16'd0);
        end
        step();
        e = sb.pop_front();
        check({name, " c"}, 16'(c), e);
        check({name, " c_any"}, 16'(c_any), 16'(e != 16'd0));
        check({name, " changed"}, 16'(changed), 16'(e != cur));
        cur = e;
    endtask

    initial begin
        vecs[0]  = '{4'b1100, 4'b1010, MODE_OR,  7, 4'b1110};
        vecs[1]  = '{4'b1100, 4'b1010, MODE_AND, 2, 4'b1000};
        vecs[2]  = '{4'b1100, 4'b1010, MODE_XOR, 2, 4'b0110};
        vecs[3]  = '{4'b1100, 4'b1010, MODE_NOR, 2, 4'b0001};
        vecs[4]  = '{4'b1100, 4'b1010, MODE_XOR, 2, 4'b0110};
        vecs[5]  = '{4'b1000, 4'b1110, MODE_XOR, 7, 4'b0110};
        vecs[6]  = '{4'b0000, 4'b0000, MODE_XOR, 7, 4'b0000};
        vecs[7]  = '{4'b0000, 4'b0000, MODE_AND, 2, 4'b0000};
        vecs[8]  = '{4'b1111, 4'b0101, MODE_AND, 7, 4'b0101};
        vecs[9]  = '{4'b1111, 4'b0101, MODE_NOR, 2, 4'b0000};
        vecs[10] = '{4'b1111, 4'b0101, MODE_OR,  2, 4'b1111};
        vecs[11] = '{4'b0000, 4'b0000, MODE_OR,  7, 4'b0000};

        rst_n = 1'b0; a = 4'b0101; b = 4'b0011; mode = MODE_OR;
        rst_n_bp = 1'b0; a_bp = 16'hFFFF; b_bp = 16'h00F0; mode_bp = MODE_AND;
        cur = 16'd0;
        step();
        step();
        check("reset c", 16'(c), 16'd0);
        check("reset c_any", 16'(c_any), 16'd0);
        check("reset changed", 16'(changed), 16'd0);

        // Reset release with inputs already stable: full 3+DB_CYCLES latency.
        rst_n = 1'b1;
        sb.push_back(16'b0111);
        expect_after("reset-release OR", 7);
        step();
        check("reset-release pulse end", 16'(changed), 16'd0);

        foreach (vecs[i]) begin
            a = vecs[i].a; b = vecs[i].b; mode = vecs[i].mode;
            sb.push_back(16'(vecs[i].exp_c));
            expect_after($sformatf("vec%0d", i), vecs[i].lat);
        end

        // Glitch of 3 cycles on a[0] must never reach c.
        a = 4'b0001;
        repeat (3) step();
        a = 4'b0000;
        for (int k = 0; k < 12; k++) begin
            step();
            check("glitch c", 16'(c), cur);
            check("glitch changed", 16'(changed), 16'd0);
        end

        // Same pulse held 4 cycles is accepted at edge 7.
        a = 4'b0001;
        sb.push_back(16'b0001);
        expect_after("accept a0", 7);

        // Reset while a[1] is mid-count, then full latency again.
        a = 4'b0011;
        repeat (4) step();
        rst_n = 1'b0;
        #1;
        check("mid-reset c", 16'(c), 16'd0);
        check("mid-reset c_any", 16'(c_any), 16'd0);
        check("mid-reset changed", 16'(changed), 16'd0);
        cur = 16'd0;
        step();
        rst_n = 1'b1;
        sb.push_back(16'b0011);
        expect_after("post-reset", 7);

        // Release with NOR selected: all-ones after 2 edges.
        rst_n = 1'b0; a = 4'b0000; b = 4'b0000; mode = MODE_NOR;
        step();
        cur = 16'd0;
        rst_n = 1'b1;
        sb.push_back(16'b1111);
        expect_after("reset NOR", 2);
        step();
        check("reset NOR pulse end", 16'(changed), 16'd0);

        // Bypass instance: 3-edge latency.
        rst_n_bp = 1'b1;
        for (int k = 1; k < 3; k++) begin
            step();
            check("bypass hold c", c_bp, 16'h0000);
        end
        step();
        check("bypass c", c_bp, 16'h00F0);
        check("bypass c_any", 16'(c_any_bp), 16'd1);
        check("bypass changed", 16'(changed_bp), 16'd1);
        b_bp = 16'h0F0F;
        repeat (2) step();
        check("bypass hold2", c_bp, 16'h00F0);
        step();
        check("bypass c2", c_bp, 16'h0F0F);
        a_bp = 16'h0000;
        repeat (3) step();
        check("bypass c3", c_bp, 16'h0000);
        check("bypass c_any3", 16'(c_any_bp), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
